// File: rtl/io_responder_if.sv
// Memory-mapped IO bus between the CPU's memory/IO router (master) and the device
// responder (slave).
interface io_responder_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        led_ctrl;
    logic        switch_ctrl;
    logic [15:0] io_read_data;

    modport master (
        output addr,
        output write_data,
        output led_ctrl,
        output switch_ctrl,
        input  io_read_data
    );

    modport slave (
        input  addr,
        input  write_data,
        input  led_ctrl,
        input  switch_ctrl,
        output io_read_data
    );
endinterface

// File: rtl/io_responder.sv
// Device-side IO responder: LED/7-segment registers, debounced switches and confirm
// button with a sticky clear-on-read flag, and a 4-digit active-low 7-segment scanner.
module io_responder #(
    parameter int unsigned DEBOUNCE_CNT = 500000,
    parameter int unsigned SCAN_DIV     = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    io_responder_if.slave bus,
    input  logic [15:0]   sw_raw,
    input  logic          btn_raw,
    output logic [15:0]   led,
    output logic [6:0]    seg_n,
    output logic [3:0]    an_n
);

    localparam logic [31:0] AddrLed = 32'hFFFF_FC60;
    localparam logic [31:0] AddrSeg = 32'hFFFF_FC64;
    localparam logic [31:0] AddrSw  = 32'hFFFF_FC70;
    localparam logic [31:0] AddrBtn = 32'hFFFF_FC74;

    localparam int unsigned DbW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int unsigned ScW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CNT - 1);
    localparam logic [ScW-1:0] ScMax = ScW'(SCAN_DIV - 1);

    // Bus decode
    logic wr_led, wr_seg, rd_btn;

    assign wr_led = bus.led_ctrl && (bus.addr == AddrLed);
    assign wr_seg = bus.led_ctrl && (bus.addr == AddrSeg);
    assign rd_btn = bus.switch_ctrl && (bus.addr == AddrBtn);

    logic unused_wdata;
    assign unused_wdata = ^bus.write_data[31:16];

    // Writable registers
    logic [15:0] led_q, seg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
            seg_q <= '0;
        end else begin
            if (wr_led) led_q <= bus.write_data[15:0];
            if (wr_seg) seg_q <= bus.write_data[15:0];
        end
    end

    assign led = led_q;

    // Two-flop synchronisers for the asynchronous inputs
    logic [15:0] sw_meta_q, sw_sync_q;
    logic        btn_meta_q, btn_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debouncers: any return to the stable value restarts the count
    logic [15:0]    sw_stable_q, sw_stable_d;
    logic [DbW-1:0] sw_cnt_q, sw_cnt_d;
    logic           btn_stable_q, btn_stable_d;
    logic [DbW-1:0] btn_cnt_q, btn_cnt_d;
    logic           btn_rise;
    logic           btn_flag_q, btn_flag_d;

    always_comb begin
        sw_cnt_d    = '0;
        sw_stable_d = sw_stable_q;
        if (sw_sync_q != sw_stable_q) begin
            if (sw_cnt_q == DbMax) begin
                sw_stable_d = sw_sync_q;
            end else begin
                sw_cnt_d = sw_cnt_q + DbW'(1);
            end
        end
    end

    always_comb begin
        btn_cnt_d    = '0;
        btn_stable_d = btn_stable_q;
        if (btn_sync_q != btn_stable_q) begin
            if (btn_cnt_q == DbMax) begin
                btn_stable_d = btn_sync_q;
            end else begin
                btn_cnt_d = btn_cnt_q + DbW'(1);
            end
        end
    end

    // Set beats the clear from a coincident BTN read
    assign btn_rise   = btn_stable_d & ~btn_stable_q;
    assign btn_flag_d = btn_rise | (btn_flag_q & ~rd_btn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable_q  <= '0;
            sw_cnt_q     <= '0;
            btn_stable_q <= 1'b0;
            btn_cnt_q    <= '0;
            btn_flag_q   <= 1'b0;
        end else begin
            sw_stable_q  <= sw_stable_d;
            sw_cnt_q     <= sw_cnt_d;
            btn_stable_q <= btn_stable_d;
            btn_cnt_q    <= btn_cnt_d;
            btn_flag_q   <= btn_flag_d;
        end
    end

    // Combinational read mux; reads see pre-write register values
    logic [15:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (bus.switch_ctrl) begin
            case (bus.addr)
                AddrLed: rd_data = led_q;
                AddrSeg: rd_data = seg_q;
                AddrSw:  rd_data = sw_stable_q;
                AddrBtn: rd_data = {15'd0, btn_flag_q};
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.io_read_data = rd_data;

    // 7-segment scanner
    logic [ScW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]     digit_q, digit_d;
    logic [3:0]     nibble;
    logic [3:0]     an_n_q, an_n_d;
    logic [6:0]     seg_n_q, seg_n_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_d = scan_cnt_q + ScW'(1);
        digit_d    = digit_q;
        if (scan_cnt_q == ScMax) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
    end

    always_comb begin
        case (digit_q)
            2'd0:    nibble = seg_q[3:0];
            2'd1:    nibble = seg_q[7:4];
            2'd2:    nibble = seg_q[11:8];
            default: nibble = seg_q[15:12];
        endcase
    end

    // Display outputs lag the digit index by one cycle
    assign an_n_d  = ~(4'b0001 << digit_q);
    assign seg_n_d = hex_to_seg(nibble);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            an_n_q     <= 4'b1110;
            seg_n_q    <= 7'b0000001;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            an_n_q     <= an_n_d;
            seg_n_q    <= seg_n_d;
        end
    end

    assign an_n  = an_n_q;
    assign seg_n = seg_n_q;

    a_an_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(~an_n));
    a_sw_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) sw_cnt_q <= DbMax);
    a_scan_range: assert property (@(posedge clk) disable iff (!rst_n) scan_cnt_q <= ScMax);

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_io_responder;

    localparam int DebCnt  = 4;
    localparam int ScanDiv = 3;
    localparam logic [31:0] AddrLed = 32'hFFFF_FC60;
    localparam logic [31:0] AddrSeg = 32'hFFFF_FC64;
    localparam logic [31:0] AddrSw  = 32'hFFFF_FC70;
    localparam logic [31:0] AddrBtn = 32'hFFFF_FC74;
    localparam logic [31:0] AddrGap = 32'hFFFF_FC68;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic        btn_raw;
    logic [15:0] led;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    io_responder_if bus ();

    io_responder #(
        .DEBOUNCE_CNT (DebCnt),
        .SCAN_DIV     (ScanDiv)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sw_raw  (sw_raw),
        .btn_raw (btn_raw),
        .led     (led),
        .seg_n   (seg_n),
        .an_n    (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: state after each clock edge
    logic [6:0]  seg_lut [16];
    logic [15:0] m_led, m_seg, m_sw_s1, m_sw_s2, m_sw_stable, m_disp_seg;
    logic        m_btn_s1, m_btn_s2, m_btn_stable, m_flag;
    int          m_sw_run, m_btn_run, m_edges, m_disp_idx;

    task automatic model_reset();
        m_led = '0; m_seg = '0; m_sw_s1 = '0; m_sw_s2 = '0; m_sw_stable = '0;
        m_btn_s1 = 1'b0; m_btn_s2 = 1'b0; m_btn_stable = 1'b0; m_flag = 1'b0;
        m_sw_run = 0; m_btn_run = 0; m_edges = 0; m_disp_idx = 0; m_disp_seg = '0;
    endtask

    task automatic model_edge();
        logic rd_btn;
        logic rise;
        rd_btn = bus.switch_ctrl && (bus.addr == AddrBtn);
        rise = 1'b0;
        m_disp_idx = (m_edges / ScanDiv) % 4;
        m_disp_seg = m_seg;
        if (m_sw_s2 != m_sw_stable) begin
            m_sw_run++;
            if (m_sw_run == DebCnt) begin
                m_sw_stable = m_sw_s2;
                m_sw_run = 0;
            end
        end else begin
            m_sw_run = 0;
        end
        if (m_btn_s2 != m_btn_stable) begin
            m_btn_run++;
            if (m_btn_run == DebCnt) begin
                rise = m_btn_s2;
                m_btn_stable = m_btn_s2;
                m_btn_run = 0;
            end
        end else begin
            m_btn_run = 0;
        end
        m_flag = rise | (m_flag & ~rd_btn);
        if (bus.led_ctrl && bus.addr == AddrLed) m_led = bus.write_data[15:0];
        if (bus.led_ctrl && bus.addr == AddrSeg) m_seg = bus.write_data[15:0];
        m_sw_s2 = m_sw_s1;
        m_sw_s1 = sw_raw;
        m_btn_s2 = m_btn_s1;
        m_btn_s1 = btn_raw;
        m_edges++;
    endtask

    function automatic logic [15:0] exp_read();
        if (!bus.switch_ctrl) return 16'h0000;
        case (bus.addr)
            AddrLed: return m_led;
            AddrSeg: return m_seg;
            AddrSw:  return m_sw_stable;
            AddrBtn: return {15'd0, m_flag};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << m_disp_idx);
    endfunction

    function automatic logic [6:0] exp_seg();
        logic [15:0] s;
        s = m_disp_seg;
        return seg_lut[s[m_disp_idx*4 +: 4]];
    endfunction

    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.led_ctrl = 1'b0;
        bus.switch_ctrl = 1'b0;
        bus.addr = 32'h0;
        bus.write_data = 32'h0;
    endtask

    task automatic run(input int n);
        idle_bus();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [15:0] exp, input string name);
        bus.led_ctrl = 1'b0;
        bus.switch_ctrl = 1'b1;
        bus.addr = a;
        #1;
        chk(name, bus.io_read_data, exp);
        step();
        bus.switch_ctrl = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
        logic [15:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [16];

    localparam logic [3:0] AnSeq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [6:0] SegSeq [4] = '{7'b0000001, 7'b1001111, 7'b0111000, 7'b0000000};

    initial begin
        logic [3:0]  prev_an;
        logic        found;
        logic [15:0] pick [5];

        seg_lut = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        vecs[0]  = '{AddrLed, 32'hABCD1234, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{AddrLed, 32'h00000000, 1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[2]  = '{AddrSw,  32'hFFFFFFFF, 1'b1, 1'b0, 16'h0000, 16'h1234};
        vecs[3]  = '{AddrSw,  32'h00000000, 1'b0, 1'b1, 16'h0000, 16'h1234};
        vecs[4]  = '{AddrBtn, 32'h00005555, 1'b1, 1'b0, 16'h0000, 16'h1234};
        vecs[5]  = '{AddrBtn, 32'h00000000, 1'b0, 1'b1, 16'h0000, 16'h1234};
        vecs[6]  = '{AddrGap, 32'h00007777, 1'b1, 1'b0, 16'h0000, 16'h1234};
        vecs[7]  = '{AddrLed, 32'h00000000, 1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[8]  = '{AddrSeg, 32'h00008F10, 1'b1, 1'b1, 16'h0000, 16'h1234};
        vecs[9]  = '{AddrSeg, 32'h00000000, 1'b0, 1'b1, 16'h8F10, 16'h1234};
        vecs[10] = '{AddrGap, 32'h00000000, 1'b0, 1'b1, 16'h0000, 16'h1234};
        vecs[11] = '{AddrLed, 32'h00000000, 1'b0, 1'b0, 16'h0000, 16'h1234};
        vecs[12] = '{AddrLed, 32'h0000BEEF, 1'b1, 1'b1, 16'h1234, 16'h1234};
        vecs[13] = '{AddrLed, 32'h00000000, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF};
        vecs[14] = '{32'hFFFFFC61, 32'h0, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
        vecs[15] = '{32'h0000FC60, 32'h0, 1'b0, 1'b1, 16'h0000, 16'hBEEF};

        // Reset state
        rst_n = 1'b0;
        sw_raw = '0;
        btn_raw = 1'b0;
        idle_bus();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", led, 16'h0000);
        chk("rst_an", 16'(an_n), 16'h000E);
        chk("rst_seg", 16'(seg_n), 16'h0001);
        chk("rst_rd_idle", bus.io_read_data, 16'h0000);
        bus.switch_ctrl = 1'b1;
        bus.addr = AddrSw;
        #1;
        chk("rst_rd_sw", bus.io_read_data, 16'h0000);
        bus.addr = AddrBtn;
        #1;
        chk("rst_rd_btn", bus.io_read_data, 16'h0000);
        idle_bus();
        #1;
        rst_n = 1'b1;
        model_reset();
        step();

        // Directed register vectors
        for (int i = 0; i < 16; i++) begin
            bus.addr = vecs[i].addr;
            bus.write_data = vecs[i].wdata;
            bus.led_ctrl = vecs[i].wr;
            bus.switch_ctrl = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d_rd", i), bus.io_read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
            step();
        end
        idle_bus();

        // Scan sequence with SEG = 0x8F10
        found = 1'b0;
        prev_an = an_n;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (prev_an == 4'b0111 && an_n == 4'b1110) found = 1'b1;
            prev_an = an_n;
        end
        chk("scan_sync", 16'(found), 16'h0001);
        if (found) begin
            for (int k = 0; k < 15; k++) begin
                chk($sformatf("scan_an%0d", k), 16'(an_n), 16'(AnSeq[(k / 3) % 4]));
                chk($sformatf("scan_seg%0d", k), 16'(seg_n), 16'(SegSeq[(k / 3) % 4]));
                step();
            end
        end

        // Switch debounce latency, then a short glitch
        bus.switch_ctrl = 1'b1;
        bus.addr = AddrSw;
        sw_raw = 16'h00F0;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("sw_db%0d", k), bus.io_read_data, (k < 6) ? 16'h0000 : 16'h00F0);
            step();
        end
        sw_raw = 16'h0001;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) sw_raw = 16'h00F0;
            #1;
            chk($sformatf("sw_glitch%0d", k), bus.io_read_data, 16'h00F0);
            step();
        end
        sw_raw = 16'h0000;
        run(8);

        // Button flag: set, clear-on-read, set-wins, held-once
        btn_raw = 1'b1;
        run(10);
        rd_chk(AddrBtn, 16'h0001, "btn_first");
        rd_chk(AddrBtn, 16'h0000, "btn_cleared");
        btn_raw = 1'b0;
        run(10);
        btn_raw = 1'b1;
        run(10);
        btn_raw = 1'b0;
        run(10);
        btn_raw = 1'b1;
        run(5);
        rd_chk(AddrBtn, 16'h0001, "btn_coinc_read");
        rd_chk(AddrBtn, 16'h0001, "btn_set_wins");
        rd_chk(AddrBtn, 16'h0000, "btn_after");
        run(5);
        rd_chk(AddrBtn, 16'h0000, "btn_held_once");
        btn_raw = 1'b0;
        run(10);

        // Asynchronous reset with a debounce in flight
        bus.led_ctrl = 1'b1;
        bus.addr = AddrLed;
        bus.write_data = 32'h0000FFFF;
        step();
        idle_bus();
        #1;
        chk("mid_led_set", led, 16'hFFFF);
        sw_raw = 16'h1234;
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led", led, 16'h0000);
        chk("mid_rst_an", 16'(an_n), 16'h000E);
        chk("mid_rst_seg", 16'(seg_n), 16'h0001);
        bus.switch_ctrl = 1'b1;
        bus.addr = AddrLed;
        #1;
        chk("mid_rst_rd_led", bus.io_read_data, 16'h0000);
        bus.addr = AddrSw;
        #1;
        chk("mid_rst_rd_sw", bus.io_read_data, 16'h0000);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("mid_db%0d", k), bus.io_read_data, (k < 6) ? 16'h0000 : 16'h1234);
            step();
        end

        // Randomized traffic against the model
        pick = '{16'h0000, 16'hA5A5, 16'h00FF, 16'h8001, 16'h1234};
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: bus.addr = AddrLed;
                1: bus.addr = AddrSeg;
                2: bus.addr = AddrSw;
                3: bus.addr = AddrBtn;
                4: bus.addr = AddrGap;
                default: bus.addr = $urandom;
            endcase
            bus.write_data = $urandom;
            bus.led_ctrl = ($urandom_range(0, 9) < 3);
            bus.switch_ctrl = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) sw_raw = pick[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) btn_raw = ~btn_raw;
            #1;
            chk("rnd_rd", bus.io_read_data, exp_read());
            chk("rnd_led", led, m_led);
            chk("rnd_an", 16'(an_n), 16'(exp_an()));
            chk("rnd_seg", 16'(seg_n), 16'(exp_seg()));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
